hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide engine and sole writer of the HI/LO register pair.
//  Executes MULT/MULTU/DIV/DIVU over 32 cycles, plus single-cycle MTHI/MTLO.
//  Datapath control issues an op and stalls on busy; MFHI/MFLO read hi/lo.
// PARAMETERS
//  WIDTH   32  operand and HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk     in   1      clock; all state changes on the rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      issue request; sampled only in IDLE
//  op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  srca    in   WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data
//  srcb    in   WIDTH  rt value: multiplier or divisor
//  busy    out  1      1 while a MUL/DIV op is in progress
//  done    out  1      1-cycle pulse; new hi/lo are visible in this cycle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; count=0. Reset aborts any op.
//  States: IDLE, MUL, DIV.
//   IDLE: start && op in {MULT,MULTU} -> MUL; start && op in {DIV,DIVU} -> DIV.
//    Both load count=WIDTH-1 and latch operands.
//    start && MTHI -> hi<=srca; start && MTLO -> lo<=srca (next edge). No done pulse; stay in IDLE.
//    op 110/111 -> no effect.
//   MUL/DIV: one iteration per cycle; count decrements each cycle.
//    At count==0, after the last iteration, hi/lo are written,
//    the state returns to IDLE, and done=1 for the following cycle.
//  Timing: start sampled at edge E0; iterations at E1..E32; hi/lo written at E32.
//   busy=1 from after E0 until E32. done=1 from E32 to E33. Latency is WIDTH cycles.
//  Operands are latched at start; srca/srcb changes while busy have no effect.
//  start while busy: ignored (no queueing). hi/lo hold their old values until the final write.
//  Signed ops: work on magnitudes (|x| as an unsigned WIDTH value).
//   Record neg_res = a[31]^b[31] and neg_rem = a[31].
//   Apply two's-complement correction at the final write.
//  MUL: shift-add on a 2*WIDTH product register; {hi,lo} = full 64-bit product.
//  DIV: restoring shift-subtract; lo = quotient truncated toward zero;
//   hi = remainder, with the sign of the dividend.
//  Divide by zero (either sign): lo=32'hFFFFFFFF, hi=original srca. Full latency still applies.
//  DIV 0x80000000 / 0xFFFFFFFF: lo=32'h80000000, hi=0 (falls out of the magnitude math).
//  done and busy are never both 1.
// STRUCTURE
//  muldiv_pkg: op encodings (OP_MULT..OP_MTLO) and the state enum (S_IDLE, S_MUL, S_DIV).
//  One sub-module, muldiv_magnitude:
//   - owns the 2*WIDTH accumulator and the count
//   - performs one add- or subtract-shift step per enable
//  The top level owns the FSM, operand/sign latching, sign fixup, and the HI/LO registers.
// TESTING
//  MULT 123 x 456 -> done at E32; hi=0, lo=0x0000DB18; busy=1 for exactly 32 cycles.
//  MULT 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU 100 / 7 -> lo=14, hi=2.
//  DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5.
//  MULT 3 x 5, then a second start (DIV) at cycle 5 -> second ignored; hi=0, lo=15.
//  MTHI 0xCAFE from IDLE -> hi=0xCAFE next cycle; busy=0, done=0.
//  MTHI then MTLO back-to-back -> both written.
//  MULT with reset asserted at cycle 10 -> next cycle: IDLE, hi=lo=0, busy=0, done=0;
//   a new MULT 2x3 then completes with lo=6.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: issue opcodes,
// FSM states and small opcode classification helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_magnitude.sv
// Unsigned iterative core: holds the 2*WIDTH accumulator and the iteration
// count, and performs one shift-add (multiply) or restoring shift-subtract
// (divide) step per enabled cycle. Signs are handled by the caller.
module muldiv_magnitude #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   init_lo,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               last
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand_q;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    // Next accumulator value for one iteration of the selected algorithm.
    // The multiplier sits in the low half and is consumed LSB first; the
    // dividend sits in the low half and quotient bits shift in behind it.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_q} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        fits     = (rem_sh >= {1'b0, operand_q});
        diff     = rem_sh - {1'b0, operand_q};
        div_next = fits ? {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        acc_next = div_mode ? div_next : mul_next;
        last     = (count == '0);
    end

    // Accumulator, latched addend/divisor and iteration count.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            operand_q <= '0;
            count     <= '0;
        end else if (load) begin
            acc       <= {{WIDTH{1'b0}}, init_lo};
            operand_q <= operand;
            count     <= CW'(WIDTH - 1);
        end else if (step) begin
            acc <= acc_next;
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit. Owns the sequencing FSM, operand and sign
// latching, the final two's-complement fixup, and the HI/LO registers.
//
//  state  | meaning
//  S_IDLE | accepts MUL/DIV issue and single-cycle MTHI/MTLO writes
//  S_MUL  | shift-add iterations on operand magnitudes
//  S_DIV  | restoring divide iterations on operand magnitudes
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;

    logic               is_signed_op;
    logic               is_div_op;
    logic               load;
    logic               step;
    logic               div_mode;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   init_lo;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   div_lo;
    logic [WIDTH-1:0]   div_hi;

    // Issue decode and operand magnitudes presented to the core on load.
    always_comb begin
        is_signed_op = op_is_signed(op);
        is_div_op    = op_is_div(op);
        a_mag        = (is_signed_op && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
        b_mag        = (is_signed_op && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;
        load         = (state == S_IDLE) && start && (op_is_mul(op) || is_div_op);
        step         = (state != S_IDLE);
        div_mode     = (state == S_IDLE) ? is_div_op : (state == S_DIV);
        init_lo      = is_div_op ? a_mag : b_mag;
        operand      = is_div_op ? b_mag : a_mag;
    end

    muldiv_magnitude #(
        .WIDTH (WIDTH)
    ) u_mag (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .div_mode (div_mode),
        .init_lo  (init_lo),
        .operand  (operand),
        .acc_next (acc_next),
        .last     (last)
    );

    // Sign fixup applied to the last iteration's result as it is written.
    // Divide-by-zero bypasses the magnitude result entirely.
    always_comb begin
        prod   = neg_res ? (~acc_next + 1'b1) : acc_next;
        quo    = acc_next[WIDTH-1:0];
        rem    = acc_next[2*WIDTH-1:WIDTH];
        div_lo = div_zero ? '1    : (neg_res ? (~quo + 1'b1) : quo);
        div_hi = div_zero ? a_raw : (neg_rem ? (~rem + 1'b1) : rem);
    end

    // Sequencing FSM with registered busy/done and the HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state    <= is_div_op ? S_DIV : S_MUL;
                                busy     <= 1'b1;
                                neg_res  <= is_signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                                neg_rem  <= is_signed_op && srca[WIDTH-1];
                                div_zero <= is_div_op && (srcb == '0);
                                a_raw    <= srca;
                            end
                            OP_MTHI: hi <= srca;
                            OP_MTLO: lo <= srca;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (last) begin
                        {hi, lo} <= prod;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (last) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: arithmetic reference model,
// per-cycle output compare, directed literal cases and randomized traffic.
module tb_hilo_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // model state
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;
    logic           m_done;
    int             m_left;
    logic [2*W-1:0] m_pend;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Arithmetic reference: returns {hi, lo}.
    function automatic logic [2*W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic signed [2*W-1:0] pa, pb;
        logic signed [W-1:0]   sa, sb, q, r;
        logic [2*W-1:0]        res;
        sa = a;
        sb = b;
        res = '0;
        case (o)
            OP_MULT: begin
                pa = sa;
                pb = sb;
                res = pa * pb;
            end
            OP_MULTU: res = {32'h0, a} * {32'h0, b};
            OP_DIV: begin
                if (b == 0)                                 res = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == '1)      res = {32'h0, 32'h80000000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r, q};
                end
            end
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else        res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Behavioural model of the unit's observable timeline.
    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                case (op)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        m_pend = ref_result(op, srca, srcb);
                        m_left = W;
                    end
                    OP_MTHI: m_hi = srca;
                    OP_MTLO: m_lo = srca;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'h0, busy}, {31'h0, (m_left > 0)});
            chk("done", {31'h0, done}, {31'h0, m_done});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit garbage, output int bcyc);
        bit seen;
        seen = 1'b0;
        bcyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) bcyc++;
                if (garbage) begin
                    srca  = $urandom;
                    srcb  = $urandom;
                    op    = 3'($urandom_range(0, 7));
                    start = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic md_lit(input string name, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int bc;
        issue(o, a, b);
        wait_done(1'b0, bc);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_busy_cycles"}, W'(bc), W'(W));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h80000000;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        logic [2:0] ro;
        reset = 1'b1; start = 1'b0; op = '0; srca = '0; srcb = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", {31'h0, busy}, '0);
        reset = 1'b0;

        md_lit("mult_123x456", OP_MULT,  32'd123,      32'd456,      32'h0,        32'h0000DB18);
        md_lit("mult_m1x2",    OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE);
        md_lit("multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        md_lit("div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        md_lit("divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        md_lit("divu_5_0",     OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        md_lit("div_min_m1",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        md_lit("div_m9_0",     OP_DIV,   32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 32'hFFFFFFFF);

        // second start while busy is ignored
        issue(OP_MULT, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        start = 1'b1; op = OP_DIV; srca = 32'd100; srcb = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, bc);
        chk("ignored_hi", hi, 32'h0);
        chk("ignored_lo", lo, 32'd15);

        // MTHI from idle
        issue(OP_MTHI, 32'hCAFE, 32'h0);
        chk("mthi_hi", hi, 32'hCAFE);
        chk("mthi_busy", {31'h0, busy}, '0);
        chk("mthi_done", {31'h0, done}, '0);

        // MTHI then MTLO back-to-back, then a no-effect opcode
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; srca = 32'h1111;
        @(negedge clk);
        op = OP_MTLO; srca = 32'h2222;
        @(negedge clk);
        op = 3'b110; srca = 32'h3333;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_hi", hi, 32'h1111);
        chk("b2b_lo", lo, 32'h2222);

        // reset in the middle of an op
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, '0);
        chk("abort_hi", hi, '0);
        chk("abort_lo", lo, '0);
        reset = 1'b0;
        md_lit("mult_2x3", OP_MULT, 32'd2, 32'd3, 32'h0, 32'd6);

        // randomized traffic with input noise while busy
        for (int k = 0; k < 80; k++) begin
            ro = 3'($urandom_range(0, 7));
            issue(ro, pick(), pick());
            if (op_is_mul(ro) || op_is_div(ro)) wait_done(1'($urandom_range(0, 1)), bc);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
